// File: rtl/cu_pkg.sv
// Shared types and constants for the LEGv8-subset control unit: states, instruction
// classes, opcodes, datapath function codes and the control-word layout.
package cu_pkg;

    typedef enum logic [2:0] {
        StInit, StFetch, StDecode, StExec, StMem, StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsR, ClsImm, ClsLdur, ClsStur, ClsB, ClsCbz, ClsBcond, ClsIllegal
    } cls_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [1:0] DTS_ALU  = 2'd0;
    localparam logic [1:0] DTS_REGB = 2'd1;
    localparam logic [1:0] DTS_PC4  = 2'd2;
    localparam logic [1:0] DTS_MEM  = 2'd3;

    localparam logic [1:0] PC_HOLD = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_ADD  = 2'd2;
    localparam logic [1:0] PC_LOAD = 2'd3;

    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_SEL  = 2'b01;

    localparam int unsigned CW_W            = 36;
    localparam int unsigned FS_LSB          = 31;
    localparam int unsigned SA_LSB          = 26;
    localparam int unsigned SB_LSB          = 21;
    localparam int unsigned DA_LSB          = 16;
    localparam int unsigned W_REG_BIT       = 15;
    localparam int unsigned C0_BIT          = 14;
    localparam int unsigned MEM_CS_LSB      = 12;
    localparam int unsigned B_SEL_BIT       = 11;
    localparam int unsigned MEM_WE_BIT      = 10;
    localparam int unsigned IR_LOAD_BIT     = 9;
    localparam int unsigned STATUS_LOAD_BIT = 8;
    localparam int unsigned SIZE_LSB        = 6;
    localparam int unsigned ADD_TRI_BIT     = 5;
    localparam int unsigned DATA_TRI_LSB    = 3;
    localparam int unsigned PC_SEL_BIT      = 2;
    localparam int unsigned PC_FS_LSB       = 0;

    typedef struct packed {
        logic [4:0] fs;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       w_reg;
        logic       c0;
        logic [1:0] mem_cs;
        logic       b_sel;
        logic       mem_write_en;
        logic       ir_load;
        logic       status_load;
        logic [1:0] size;
        logic       add_tri_sel;
        logic [1:0] data_tri_sel;
        logic       pc_sel;
        logic [1:0] pc_fs;
    } cw_t;

    function automatic logic [CW_W-1:0] pack_cw(input cw_t c);
        logic [CW_W-1:0] w;
        w = '0;
        w[FS_LSB +: 5]       = c.fs;
        w[SA_LSB +: 5]       = c.sa;
        w[SB_LSB +: 5]       = c.sb;
        w[DA_LSB +: 5]       = c.da;
        w[W_REG_BIT]         = c.w_reg;
        w[C0_BIT]            = c.c0;
        w[MEM_CS_LSB +: 2]   = c.mem_cs;
        w[B_SEL_BIT]         = c.b_sel;
        w[MEM_WE_BIT]        = c.mem_write_en;
        w[IR_LOAD_BIT]       = c.ir_load;
        w[STATUS_LOAD_BIT]   = c.status_load;
        w[SIZE_LSB +: 2]     = c.size;
        w[ADD_TRI_BIT]       = c.add_tri_sel;
        w[DATA_TRI_LSB +: 2] = c.data_tri_sel;
        w[PC_SEL_BIT]        = c.pc_sel;
        w[PC_FS_LSB +: 2]    = c.pc_fs;
        return w;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: classifies IR, selects the ALU function, extracts
// register fields and all immediate forms, and evaluates the B.cond condition.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [31:0] ir,
    input  logic [3:0]  status,
    output cls_e        cls,
    output logic [4:0]  alu_fs,
    output logic        alu_c0,
    output logic        set_flags,
    output logic        cond_taken,
    output logic [4:0]  rn,
    output logic [4:0]  rm,
    output logic [4:0]  rt,
    output logic [63:0] k_imm,
    output logic [63:0] k_dt,
    output logic [63:0] k_br,
    output logic [63:0] k_cb
);

    logic z, n, v;
    logic cond_ok;
    logic unused_carry;

    assign z            = status[0];
    assign n            = status[1];
    assign v            = status[3];
    assign unused_carry = status[2];

    assign rn    = ir[9:5];
    assign rm    = ir[20:16];
    assign rt    = ir[4:0];
    assign k_imm = {52'd0, ir[21:10]};
    assign k_dt  = {{55{ir[20]}}, ir[20:12]};
    assign k_br  = {{36{ir[25]}}, ir[25:0], 2'b00};
    assign k_cb  = {{43{ir[23]}}, ir[23:5], 2'b00};

    always_comb begin
        cond_ok    = 1'b1;
        cond_taken = 1'b0;
        case (ir[3:0])
            COND_EQ: cond_taken = z;
            COND_NE: cond_taken = !z;
            COND_GE: cond_taken = (n == v);
            COND_LT: cond_taken = (n != v);
            default: cond_ok = 1'b0;
        endcase
    end

    // Widest opcode field wins; the subset has no overlaps so order only matters for speed.
    always_comb begin
        cls       = ClsIllegal;
        alu_fs    = FS_AND;
        alu_c0    = 1'b0;
        set_flags = 1'b0;
        case (ir[31:21])
            OP_ADD:  begin cls = ClsR; alu_fs = FS_ADD; end
            OP_ADDS: begin cls = ClsR; alu_fs = FS_ADD; set_flags = 1'b1; end
            OP_SUB:  begin cls = ClsR; alu_fs = FS_SUB; alu_c0 = 1'b1; end
            OP_SUBS: begin cls = ClsR; alu_fs = FS_SUB; alu_c0 = 1'b1; set_flags = 1'b1; end
            OP_AND:  begin cls = ClsR; alu_fs = FS_AND; end
            OP_ORR:  begin cls = ClsR; alu_fs = FS_OR; end
            OP_LDUR: begin cls = ClsLdur; alu_fs = FS_ADD; end
            OP_STUR: begin cls = ClsStur; alu_fs = FS_ADD; end
            default: begin
                if (ir[31:22] == OP_ADDI) begin
                    cls    = ClsImm;
                    alu_fs = FS_ADD;
                end else if (ir[31:22] == OP_SUBI) begin
                    cls    = ClsImm;
                    alu_fs = FS_SUB;
                    alu_c0 = 1'b1;
                end else if (ir[31:24] == OP_CBZ) begin
                    cls = ClsCbz;
                end else if (ir[31:24] == OP_BCOND) begin
                    cls = cond_ok ? ClsBcond : ClsIllegal;
                end else if (ir[31:26] == OP_B) begin
                    cls = ClsB;
                end
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle LEGv8-subset sequencer driving the datapath control word and constant k.
// Define CU_HALT_EN to trap illegal instructions in a sticky HALT state.
module control_unit
    import cu_pkg::*;
#(
    parameter logic [1:0] FETCH_SIZE = 2'b10,
    parameter logic [1:0] DATA_SIZE  = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_out,
    input  logic [3:0]  status,
    input  logic [63:0] data_bus,
    input  logic        mem_ready,
    output logic [35:0] controlWord,
    output logic [63:0] k,
    output logic        halted
);

    state_e state_q, state_d;
    cls_e   cls_q;
    cls_e   dec_cls;
    logic [4:0]  dec_fs, dec_rn, dec_rm, dec_rt;
    logic        dec_c0, dec_set_flags, dec_taken;
    logic [63:0] k_imm, k_dt, k_br, k_cb;
    cw_t         cw;

    cu_decoder u_decoder (
        .ir        (IR_out),
        .status    (status),
        .cls       (dec_cls),
        .alu_fs    (dec_fs),
        .alu_c0    (dec_c0),
        .set_flags (dec_set_flags),
        .cond_taken(dec_taken),
        .rn        (dec_rn),
        .rm        (dec_rm),
        .rt        (dec_rt),
        .k_imm     (k_imm),
        .k_dt      (k_dt),
        .k_br      (k_br),
        .k_cb      (k_cb)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            cls_q   <= ClsR;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                cls_q <= dec_cls;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                if (dec_cls == ClsLdur || dec_cls == ClsStur) begin
                    state_d = StMem;
`ifdef CU_HALT_EN
                end else if (dec_cls == ClsIllegal) begin
                    state_d = StHalt;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec:   state_d = StFetch;
            StMem:    if (mem_ready) state_d = StFetch;
`ifdef CU_HALT_EN
            StHalt:   state_d = StHalt;
`endif
            default:  state_d = StInit;
        endcase
    end

    // IR_out is stable from DECODE until the next fetch, so EXEC/MEM re-use the decoder.
    always_comb begin
        cw = '0;
        k  = '0;
        case (state_q)
            StFetch: begin
                cw.add_tri_sel  = 1'b1;
                cw.data_tri_sel = DTS_MEM;
                cw.mem_cs       = MEM_SEL;
                cw.size         = FETCH_SIZE;
                cw.ir_load      = mem_ready;
            end
            StExec: begin
                case (cls_q)
                    ClsR, ClsImm: begin
                        cw.fs           = dec_fs;
                        cw.c0           = dec_c0;
                        cw.sa           = dec_rn;
                        cw.sb           = dec_rm;
                        cw.da           = dec_rt;
                        cw.w_reg        = 1'b1;
                        cw.data_tri_sel = DTS_ALU;
                        cw.pc_fs        = PC_INC;
                        if (cls_q == ClsImm) begin
                            cw.b_sel = 1'b1;
                            k        = k_imm;
                        end else begin
                            cw.status_load = dec_set_flags;
                        end
                    end
                    ClsB: begin
                        cw.pc_sel = 1'b1;
                        cw.pc_fs  = PC_ADD;
                        k         = k_br;
                    end
                    ClsCbz: begin
                        cw.sb           = dec_rt;
                        cw.data_tri_sel = DTS_REGB;
                        cw.pc_sel       = 1'b1;
                        cw.pc_fs        = (data_bus == 64'd0) ? PC_ADD : PC_INC;
                        k               = k_cb;
                    end
                    ClsBcond: begin
                        cw.pc_sel = dec_taken;
                        cw.pc_fs  = dec_taken ? PC_ADD : PC_INC;
                        k         = k_cb;
                    end
                    default: cw.pc_fs = PC_INC;
                endcase
            end
            StMem: begin
                cw.sa          = dec_rn;
                cw.b_sel       = 1'b1;
                cw.fs          = FS_ADD;
                cw.add_tri_sel = 1'b0;
                cw.mem_cs      = MEM_SEL;
                cw.size        = DATA_SIZE;
                cw.pc_fs       = mem_ready ? PC_INC : PC_HOLD;
                k              = k_dt;
                if (cls_q == ClsLdur) begin
                    cw.data_tri_sel = DTS_MEM;
                    cw.da           = mem_ready ? dec_rt : 5'd0;
                    cw.w_reg        = mem_ready;
                end else begin
                    cw.sb           = dec_rt;
                    cw.data_tri_sel = DTS_REGB;
                    cw.mem_write_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign controlWord = pack_cw(cw);

`ifdef CU_HALT_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a vector table of single-instruction EXEC words plus
// hand-written sequences for fetch stalls, memory waits, reset mid-access and illegal ops.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IR_out;
    logic [3:0]  status;
    logic [63:0] data_bus;
    logic        mem_ready;
    logic [35:0] controlWord;
    logic [63:0] k;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [63:0] db;
        logic [35:0] cw;
        logic [63:0] k;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    control_unit dut (
        .clock      (clock),
        .reset      (reset),
        .IR_out     (IR_out),
        .status     (status),
        .data_bus   (data_bus),
        .mem_ready  (mem_ready),
        .controlWord(controlWord),
        .k          (k),
        .halted     (halted)
    );

    function automatic logic [35:0] mk(
        input logic [4:0] fs, input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
        input logic w, input logic c0, input logic [1:0] mcs, input logic bsel, input logic mwe,
        input logic irl, input logic sl, input logic [1:0] sz, input logic ats,
        input logic [1:0] dts, input logic psel, input logic [1:0] pfs);
        return {fs, sa, sb, da, w, c0, mcs, bsel, mwe, irl, sl, sz, ats, dts, psel, pfs};
    endfunction

    function automatic logic [35:0] alu(input logic [4:0] fs, input logic c0, input logic [4:0] sa,
        input logic [4:0] sb, input logic [4:0] da, input logic bsel, input logic sl);
        return mk(fs, sa, sb, da, 1'b1, c0, 2'b00, bsel, 1'b0, 1'b0, sl, 2'b00, 1'b0, 2'd0,
                  1'b0, 2'd1);
    endfunction

    function automatic logic [35:0] br(input logic [4:0] sb, input logic [1:0] dts,
        input logic psel, input logic [1:0] pfs);
        return mk(5'd0, 5'd0, sb, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
                  dts, psel, pfs);
    endfunction

    function automatic logic [35:0] fetch_cw(input logic rdy);
        return mk(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 1'b1,
                  2'd3, 1'b0, 2'd0);
    endfunction

    task automatic add(input string name, input logic [31:0] ir, input logic [3:0] st,
        input logic [63:0] db, input logic [35:0] cw, input logic [63:0] kv);
        vec_t v;
        v.name = name; v.ir = ir; v.st = st; v.db = db; v.cw = cw; v.k = kv;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered in FETCH; leaves the DUT in EXEC (or MEM) with IR_out = ir.
    task automatic fetch_insn(input logic [31:0] ir);
        IR_out    = ir;
        mem_ready = 1'b1;
        #1;
        check("fetch_ready", {28'd0, controlWord}, {28'd0, fetch_cw(1'b1)});
        tick();
        mem_ready = 1'b0;
        #1;
        check("decode_nop", {28'd0, controlWord}, 64'd0);
        check("decode_k", k, 64'd0);
        tick();
    endtask

    task automatic illegal_seq(input string name, input logic [31:0] ir);
        fetch_insn(ir);
`ifdef CU_HALT_EN
        check({name, "_halted"}, {63'd0, halted}, 64'd1);
        check({name, "_halt_cw"}, {28'd0, controlWord}, 64'd0);
        mem_ready = 1'b1;
        tick();
        tick();
        check({name, "_halt_sticky"}, {63'd0, halted}, 64'd1);
        check({name, "_halt_cw2"}, {28'd0, controlWord}, 64'd0);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check({name, "_halt_clear"}, {63'd0, halted}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
`else
        check({name, "_exec_cw"}, {28'd0, controlWord}, 64'd1);
        check({name, "_exec_k"}, k, 64'd0);
        check({name, "_halted"}, {63'd0, halted}, 64'd0);
        tick();
`endif
        check({name, "_refetch"}, {28'd0, controlWord}, {28'd0, fetch_cw(1'b0)});
    endtask

    initial begin
        reset = 1'b1; IR_out = '0; status = '0; data_bus = '0; mem_ready = 1'b0;

        add("add",    32'h8B020023, 4'b0000, 64'd0, alu(5'b01000, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0), 64'd0);
        add("adds",   32'hAB020023, 4'b0100, 64'd0, alu(5'b01000, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1), 64'd0);
        add("sub",    32'hCB020023, 4'b0000, 64'd0, alu(5'b01001, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0), 64'd0);
        add("subs",   32'hEB020023, 4'b0000, 64'd0, alu(5'b01001, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1), 64'd0);
        add("and",    32'h8A020023, 4'b0000, 64'd0, alu(5'b00000, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0), 64'd0);
        add("orr",    32'hAA020023, 4'b0000, 64'd0, alu(5'b00100, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0), 64'd0);
        add("addi",   32'h91001423, 4'b0000, 64'd0, alu(5'b01000, 1'b0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0), 64'd5);
        add("subi",   32'hD1001423, 4'b0000, 64'd0, alu(5'b01001, 1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0), 64'd5);
        add("addi_max", 32'h913FFC23, 4'b0000, 64'd0, alu(5'b01000, 1'b0, 5'd1, 5'd31, 5'd3, 1'b1, 1'b0), 64'hFFF);
        add("b_back", 32'h17FFFFFF, 4'b0000, 64'd0, br(5'd0, 2'd0, 1'b1, 2'd2), 64'hFFFF_FFFF_FFFF_FFFC);
        add("b_fwd",  32'h14000003, 4'b0000, 64'd0, br(5'd0, 2'd0, 1'b1, 2'd2), 64'd12);
        add("cbz_taken", 32'hB4000064, 4'b0000, 64'd0, br(5'd4, 2'd1, 1'b1, 2'd2), 64'd12);
        add("cbz_not",   32'hB4000064, 4'b0000, 64'd5, br(5'd4, 2'd1, 1'b1, 2'd1), 64'd12);
        add("cbz_neg",   32'hB4FFFFE4, 4'b0000, 64'd0, br(5'd4, 2'd1, 1'b1, 2'd2), 64'hFFFF_FFFF_FFFF_FFFC);
        add("beq_taken", 32'h54000040, 4'b0001, 64'd0, br(5'd0, 2'd0, 1'b1, 2'd2), 64'd8);
        add("beq_not",   32'h54000040, 4'b0000, 64'd0, br(5'd0, 2'd0, 1'b0, 2'd1), 64'd8);
        add("bne_taken", 32'h54000041, 4'b0000, 64'd0, br(5'd0, 2'd0, 1'b1, 2'd2), 64'd8);
        add("bne_not",   32'h54000041, 4'b0001, 64'd0, br(5'd0, 2'd0, 1'b0, 2'd1), 64'd8);
        add("bge_taken", 32'h5400004A, 4'b1010, 64'd0, br(5'd0, 2'd0, 1'b1, 2'd2), 64'd8);
        add("bge_not",   32'h5400004A, 4'b0010, 64'd0, br(5'd0, 2'd0, 1'b0, 2'd1), 64'd8);
        add("blt_taken", 32'h5400004B, 4'b0010, 64'd0, br(5'd0, 2'd0, 1'b1, 2'd2), 64'd8);
        add("blt_not",   32'h5400004B, 4'b1010, 64'd0, br(5'd0, 2'd0, 1'b0, 2'd1), 64'd8);

        tick();
        tick();
        check("reset_cw", {28'd0, controlWord}, 64'd0);
        check("reset_k", k, 64'd0);
        check("reset_halted", {63'd0, halted}, 64'd0);
        reset = 1'b0;
        #1;
        check("init_cw", {28'd0, controlWord}, 64'd0);
        tick();

        // FETCH must hold while mem_ready stays low.
        for (int i = 0; i < 3; i++) begin
            check("fetch_stall", {28'd0, controlWord}, {28'd0, fetch_cw(1'b0)});
            tick();
        end

        foreach (vecs[i]) begin
            status   = vecs[i].st;
            data_bus = vecs[i].db;
            fetch_insn(vecs[i].ir);
            check({vecs[i].name, "_cw"}, {28'd0, controlWord}, {28'd0, vecs[i].cw});
            check({vecs[i].name, "_k"}, k, vecs[i].k);
            tick();
            check({vecs[i].name, "_refetch"}, {28'd0, controlWord}, {28'd0, fetch_cw(1'b0)});
        end
        status   = '0;
        data_bus = '0;

        // LDUR with two wait cycles in MEM.
        fetch_insn(32'hF8408045);
        for (int i = 0; i < 2; i++) begin
            check("ldur_wait_cw", {28'd0, controlWord},
                  {28'd0, mk(5'b01000, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0,
                             2'b11, 1'b0, 2'd3, 1'b0, 2'd0)});
            check("ldur_wait_k", k, 64'd8);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("ldur_ready_cw", {28'd0, controlWord},
              {28'd0, mk(5'b01000, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0,
                         2'b11, 1'b0, 2'd3, 1'b0, 2'd1)});
        check("ldur_ready_k", k, 64'd8);
        tick();
        mem_ready = 1'b0;
        #1;
        check("ldur_refetch", {28'd0, controlWord}, {28'd0, fetch_cw(1'b0)});

        // STUR interrupted by reset mid-access.
        fetch_insn(32'hF8008045);
        check("stur_mem_cw", {28'd0, controlWord},
              {28'd0, mk(5'b01000, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0,
                         2'b11, 1'b0, 2'd1, 1'b0, 2'd0)});
        check("stur_mem_k", k, 64'd8);
        #2;
        reset = 1'b1;
        #1;
        check("stur_reset_cw", {28'd0, controlWord}, 64'd0);
        check("stur_reset_k", k, 64'd0);
        tick();
        check("stur_reset_hold", {28'd0, controlWord}, 64'd0);
        reset = 1'b0;
        #1;
        check("stur_release_init", {28'd0, controlWord}, 64'd0);
        tick();
        check("stur_release_fetch", {28'd0, controlWord}, {28'd0, fetch_cw(1'b0)});

        illegal_seq("ill_zero", 32'h00000000);
        illegal_seq("ill_cond", 32'h54000042);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
